// File: rtl/cacheline_arbiter_if.sv
// Cacheline port bundle between the three requesters, the arbiter and main memory.
// The arbiter takes the slave view; requesters plus memory together form the master view.
interface cacheline_arbiter_if;
  logic         icache_pmem_read;
  logic [31:0]  icache_pmem_address;
  logic         icache_pmem_resp;

  logic         dcache_pmem_read;
  logic         dcache_pmem_write;
  logic [31:0]  dcache_pmem_address;
  logic [255:0] dcache_pmem_wdata_256;
  logic         dcache_pmem_resp;

  logic         pref_pmem_read;
  logic [31:0]  pref_pmem_address;
  logic         pref_pmem_resp;

  logic [255:0] pmem_rdata_256_out;
  logic         arbiter_idle;

  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata_256;
  logic         pmem_resp;
  logic [255:0] pmem_rdata_256;

  modport slave (
    input  icache_pmem_read, icache_pmem_address,
    input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata_256,
    input  pref_pmem_read, pref_pmem_address,
    input  pmem_resp, pmem_rdata_256,
    output icache_pmem_resp, dcache_pmem_resp, pref_pmem_resp,
    output pmem_rdata_256_out, arbiter_idle,
    output pmem_read, pmem_write, pmem_address, pmem_wdata_256
  );

  modport master (
    output icache_pmem_read, icache_pmem_address,
    output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata_256,
    output pref_pmem_read, pref_pmem_address,
    output pmem_resp, pmem_rdata_256,
    input  icache_pmem_resp, dcache_pmem_resp, pref_pmem_resp,
    input  pmem_rdata_256_out, arbiter_idle,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata_256
  );
endinterface

// File: rtl/cacheline_arbiter.sv
// Shares the 256-bit cacheline memory port between I-cache, D-cache and prefetcher.
// Caches alternate round-robin; the prefetcher only gets cycles the caches leave idle.
module cacheline_arbiter (
  input  logic               clk,
  input  logic               rst,
  cacheline_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  typedef enum logic [1:0] {
    OWN_ICACHE = 2'd0,
    OWN_DCACHE = 2'd1,
    OWN_PREF   = 2'd2
  } owner_e;

  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

  state_e       state_q, state_d;
  owner_e       owner_q, owner_d;
  logic         rr_q, rr_d;
  logic         write_q, write_d;
  logic [31:0]  addr_q, addr_d;
  logic [255:0] wdata_q, wdata_d;

  logic icache_req;
  logic dcache_req;
  logic grant_dcache;
  logic icache_resp;
  logic dcache_resp;
  logic pref_resp;

  assign icache_req = bus.icache_pmem_read;
  assign dcache_req = bus.dcache_pmem_read | bus.dcache_pmem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_ICACHE;
      rr_q    <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // rr_q low prefers the D-cache; after any cache grant it points at the other cache.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    grant_dcache = 1'b0;
    icache_resp  = 1'b0;
    dcache_resp  = 1'b0;
    pref_resp    = 1'b0;

    case (state_q)
      IDLE: begin
        if (icache_req || dcache_req) begin
          grant_dcache = dcache_req && (!icache_req || !rr_q);
          rr_d         = grant_dcache;
          state_d      = BUSY;
          if (grant_dcache) begin
            owner_d = OWN_DCACHE;
            write_d = bus.dcache_pmem_write;
            addr_d  = bus.dcache_pmem_address & LINE_MASK;
            wdata_d = bus.dcache_pmem_write ? bus.dcache_pmem_wdata_256 : '0;
          end else begin
            owner_d = OWN_ICACHE;
            write_d = 1'b0;
            addr_d  = bus.icache_pmem_address & LINE_MASK;
            wdata_d = '0;
          end
        end else if (bus.pref_pmem_read) begin
          state_d = BUSY;
          owner_d = OWN_PREF;
          write_d = 1'b0;
          addr_d  = bus.pref_pmem_address & LINE_MASK;
          wdata_d = '0;
        end
      end

      BUSY: begin
        if (bus.pmem_resp) begin
          state_d = IDLE;
          // A completion arriving during reset belongs to an abandoned transaction.
          if (!rst) begin
            case (owner_q)
              OWN_ICACHE: icache_resp = 1'b1;
              OWN_DCACHE: dcache_resp = 1'b1;
              OWN_PREF:   pref_resp   = 1'b1;
              default:    ;
            endcase
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.icache_pmem_resp   = icache_resp;
  assign bus.dcache_pmem_resp   = dcache_resp;
  assign bus.pref_pmem_resp     = pref_resp;

  assign bus.pmem_read          = (state_q == BUSY) && !write_q;
  assign bus.pmem_write         = (state_q == BUSY) && write_q;
  assign bus.pmem_address       = addr_q;
  assign bus.pmem_wdata_256     = wdata_q;
  assign bus.pmem_rdata_256_out = bus.pmem_rdata_256;
  assign bus.arbiter_idle       = (state_q == IDLE) && !icache_req && !dcache_req;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a transaction-level model of the arbiter.
module tb_cacheline_arbiter;

  localparam int OWN_I = 0;
  localparam int OWN_D = 1;
  localparam int OWN_P = 2;

  logic clk = 1'b0;
  logic rst;

  cacheline_arbiter_if bus ();

  cacheline_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit           busy;
    int           owner;
    bit           write;
    logic [31:0]  addr;
    logic [255:0] wdata;
    int           last_cache;
    bit           virgin;
  } model_t;

  model_t m;
  bit     m_valid = 1'b0;

  int           fixed_lat   = 4;
  bit           spurious_en = 1'b0;
  int           cmd_cycles  = 0;
  int           target      = 1;
  logic [255:0] last_rdata  = '0;
  bit           i_resp_prev = 1'b0;
  bit           d_resp_prev = 1'b0;
  bit           p_resp_prev = 1'b0;

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Transaction-level view: who owns the port, what was captured at grant time.
  function automatic model_t model_next(model_t cur);
    model_t nx = cur;
    bit want_i;
    bit want_d;
    int winner;
    want_i = bus.icache_pmem_read;
    want_d = bus.dcache_pmem_read || bus.dcache_pmem_write;
    if (rst) begin
      nx.busy       = 1'b0;
      nx.owner      = OWN_I;
      nx.write      = 1'b0;
      nx.addr       = '0;
      nx.wdata      = '0;
      nx.last_cache = OWN_I;
      nx.virgin     = 1'b1;
    end else if (!cur.busy) begin
      if (want_i || want_d) begin
        if (want_i && want_d) winner = (cur.last_cache == OWN_D) ? OWN_I : OWN_D;
        else                  winner = want_d ? OWN_D : OWN_I;
        nx.last_cache = winner;
        nx.busy       = 1'b1;
        nx.virgin     = 1'b0;
        nx.owner      = winner;
        nx.write      = (winner == OWN_D) && bus.dcache_pmem_write;
        nx.addr       = ((winner == OWN_D) ? bus.dcache_pmem_address
                                           : bus.icache_pmem_address) & 32'hFFFF_FFE0;
        nx.wdata      = nx.write ? bus.dcache_pmem_wdata_256 : '0;
      end else if (bus.pref_pmem_read) begin
        nx.busy   = 1'b1;
        nx.virgin = 1'b0;
        nx.owner  = OWN_P;
        nx.write  = 1'b0;
        nx.addr   = bus.pref_pmem_address & 32'hFFFF_FFE0;
        nx.wdata  = '0;
      end
    end else if (bus.pmem_resp) begin
      nx.busy = 1'b0;
    end
    return nx;
  endfunction

  always @(posedge clk) begin
    m       <= model_next(m);
    m_valid <= m_valid | rst;
  end

  task automatic check_output(input string name, input logic [255:0] actual,
                              input logic [255:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic compare_all();
    logic fire;
    if (!m_valid) return;
    fire = !rst && m.busy && bus.pmem_resp;
    check_output("pmem_read", bus.pmem_read, m.busy && !m.write);
    check_output("pmem_write", bus.pmem_write, m.busy && m.write);
    check_output("icache_resp", bus.icache_pmem_resp, fire && (m.owner == OWN_I));
    check_output("dcache_resp", bus.dcache_pmem_resp, fire && (m.owner == OWN_D));
    check_output("pref_resp", bus.pref_pmem_resp, fire && (m.owner == OWN_P));
    check_output("rdata_out", bus.pmem_rdata_256_out, bus.pmem_rdata_256);
    check_output("arbiter_idle", bus.arbiter_idle,
                 !m.busy && !bus.icache_pmem_read && !bus.dcache_pmem_read
                 && !bus.dcache_pmem_write);
    if (m.busy || m.virgin) begin
      check_output("pmem_address", bus.pmem_address, m.addr);
      check_output("pmem_wdata", bus.pmem_wdata_256, m.wdata);
    end
  endtask

  // Memory answers a command after a fixed or random number of command cycles.
  task automatic mem_step();
    logic cmd;
    cmd = bus.pmem_read || bus.pmem_write;
    if (bus.pmem_resp) begin
      bus.pmem_resp = 1'b0;
      cmd_cycles    = 0;
    end else if (cmd) begin
      cmd_cycles++;
      if (cmd_cycles == 1) target = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
      if (cmd_cycles >= target) begin
        last_rdata         = rand256();
        bus.pmem_rdata_256 = last_rdata;
        bus.pmem_resp      = 1'b1;
      end
    end else begin
      cmd_cycles = 0;
      if (spurious_en && $urandom_range(0, 15) == 0) begin
        bus.pmem_rdata_256 = rand256();
        bus.pmem_resp      = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
    mem_step();
  endtask

  function automatic logic resp_of(input int which);
    case (which)
      OWN_I:   return bus.icache_pmem_resp;
      OWN_D:   return bus.dcache_pmem_resp;
      default: return bus.pref_pmem_resp;
    endcase
  endfunction

  task automatic wait_resp(input string name, input int which, output int cycles);
    logic got;
    got    = 1'b0;
    cycles = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (resp_of(which)) begin
        got = 1'b1;
        break;
      end
      tick();
      cycles++;
    end
    check_output({name, "_resp_seen"}, got, 1'b1);
  endtask

  task automatic apply_stimulus();
    bit w;
    if (i_resp_prev) bus.icache_pmem_read = 1'b0;
    else if (bus.icache_pmem_read) begin
      if ($urandom_range(0, 3) == 0) bus.icache_pmem_address = $urandom;
    end else if ($urandom_range(0, 3) == 0) begin
      bus.icache_pmem_read    = 1'b1;
      bus.icache_pmem_address = $urandom;
    end

    if (d_resp_prev) begin
      bus.dcache_pmem_read  = 1'b0;
      bus.dcache_pmem_write = 1'b0;
    end else if (bus.dcache_pmem_read || bus.dcache_pmem_write) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.dcache_pmem_address   = $urandom;
        bus.dcache_pmem_wdata_256 = rand256();
      end
    end else if ($urandom_range(0, 3) == 0) begin
      w = 1'($urandom_range(0, 1));
      bus.dcache_pmem_read      = !w;
      bus.dcache_pmem_write     = w;
      bus.dcache_pmem_address   = $urandom;
      bus.dcache_pmem_wdata_256 = rand256();
    end

    if (p_resp_prev) bus.pref_pmem_read = 1'b0;
    else if (!bus.pref_pmem_read && $urandom_range(0, 2) == 0) begin
      bus.pref_pmem_read    = 1'b1;
      bus.pref_pmem_address = $urandom;
    end
  endtask

  initial begin : main
    int c;
    int order[$];
    rst                       = 1'b1;
    bus.icache_pmem_read      = 1'b0;
    bus.icache_pmem_address   = '0;
    bus.dcache_pmem_read      = 1'b0;
    bus.dcache_pmem_write     = 1'b0;
    bus.dcache_pmem_address   = '0;
    bus.dcache_pmem_wdata_256 = '0;
    bus.pref_pmem_read        = 1'b0;
    bus.pref_pmem_address     = '0;
    bus.pmem_resp             = 1'b0;
    bus.pmem_rdata_256        = '0;

    tick();
    tick();
    rst = 1'b0;
    #1;
    check_output("reset_pmem_read", bus.pmem_read, 1'b0);
    check_output("reset_pmem_write", bus.pmem_write, 1'b0);
    check_output("reset_address", bus.pmem_address, 32'h0);
    check_output("reset_wdata", bus.pmem_wdata_256, 256'h0);
    check_output("reset_idle", bus.arbiter_idle, 1'b1);

    // Single I-cache read, 4-cycle memory.
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 32'h0000_1234;
    #1 check_output("t1_idle_low", bus.arbiter_idle, 1'b0);
    tick();
    #1;
    check_output("t1_pmem_read", bus.pmem_read, 1'b1);
    check_output("t1_address", bus.pmem_address, 32'h0000_1220);
    wait_resp("t1", OWN_I, c);
    check_output("t1_latency", c, 3);
    check_output("t1_rdata", bus.pmem_rdata_256_out, last_rdata);
    check_output("t1_dcache_resp", bus.dcache_pmem_resp, 1'b0);
    check_output("t1_cmd_at_resp", bus.pmem_read, 1'b1);
    tick();
    bus.icache_pmem_read = 1'b0;
    #1;
    check_output("t1_cmd_drop", bus.pmem_read, 1'b0);
    check_output("t1_idle_after", bus.arbiter_idle, 1'b1);

    // D-cache write; inputs turn to garbage once granted.
    bus.dcache_pmem_write     = 1'b1;
    bus.dcache_pmem_address   = 32'h0000_0040;
    bus.dcache_pmem_wdata_256 = {32{8'hA5}};
    tick();
    bus.dcache_pmem_address   = 32'hDEAD_BEEF;
    bus.dcache_pmem_wdata_256 = rand256();
    #1;
    check_output("t2_pmem_write", bus.pmem_write, 1'b1);
    check_output("t2_pmem_read", bus.pmem_read, 1'b0);
    check_output("t2_address", bus.pmem_address, 32'h0000_0040);
    check_output("t2_wdata", bus.pmem_wdata_256, {32{8'hA5}});
    wait_resp("t2", OWN_D, c);
    check_output("t2_address_end", bus.pmem_address, 32'h0000_0040);
    check_output("t2_icache_resp", bus.icache_pmem_resp, 1'b0);
    tick();
    bus.dcache_pmem_write = 1'b0;

    // I and D held together from reset: grant order D, I, D, I.
    fixed_lat = 2;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 32'h0000_0100;
    bus.dcache_pmem_read    = 1'b1;
    bus.dcache_pmem_address = 32'h0000_0200;
    i_resp_prev = 1'b0;
    d_resp_prev = 1'b0;
    for (int k = 0; k < 80 && order.size() < 4; k++) begin
      tick();
      bus.icache_pmem_read = !i_resp_prev;
      bus.dcache_pmem_read = !d_resp_prev;
      #1;
      i_resp_prev = bus.icache_pmem_resp;
      d_resp_prev = bus.dcache_pmem_resp;
      if (d_resp_prev) order.push_back(OWN_D);
      if (i_resp_prev) order.push_back(OWN_I);
    end
    check_output("t3_count", order.size(), 4);
    while (order.size() < 4) order.push_back(-1);
    check_output("t3_grant0", order[0], OWN_D);
    check_output("t3_grant1", order[1], OWN_I);
    check_output("t3_grant2", order[2], OWN_D);
    check_output("t3_grant3", order[3], OWN_I);
    tick();
    bus.icache_pmem_read = 1'b0;
    bus.dcache_pmem_read = 1'b0;
    i_resp_prev = 1'b0;
    d_resp_prev = 1'b0;

    // Prefetch raised with a D-cache read: D first, prefetch once caches are quiet.
    tick();
    bus.pref_pmem_read      = 1'b1;
    bus.pref_pmem_address   = 32'h0000_0060;
    bus.dcache_pmem_read    = 1'b1;
    bus.dcache_pmem_address = 32'h0000_0080;
    #1 check_output("t4_idle_low", bus.arbiter_idle, 1'b0);
    tick();
    #1;
    check_output("t4_d_first", bus.pmem_address, 32'h0000_0080);
    wait_resp("t4_d", OWN_D, c);
    check_output("t4_pref_resp", bus.pref_pmem_resp, 1'b0);
    tick();
    bus.dcache_pmem_read = 1'b0;
    #1;
    check_output("t4_idle_gap", bus.arbiter_idle, 1'b1);
    tick();
    #1;
    check_output("t4_pref_read", bus.pmem_read, 1'b1);
    check_output("t4_pref_address", bus.pmem_address, 32'h0000_0060);
    check_output("t4_busy_idle", bus.arbiter_idle, 1'b0);
    wait_resp("t4_p", OWN_P, c);
    tick();
    bus.pref_pmem_read = 1'b0;

    // Spurious completion while idle.
    tick();
    bus.pmem_rdata_256 = rand256();
    bus.pmem_resp      = 1'b1;
    #1;
    check_output("t5_icache_resp", bus.icache_pmem_resp, 1'b0);
    check_output("t5_dcache_resp", bus.dcache_pmem_resp, 1'b0);
    check_output("t5_pref_resp", bus.pref_pmem_resp, 1'b0);
    tick();
    #1;
    check_output("t5_no_cmd", bus.pmem_read || bus.pmem_write, 1'b0);
    check_output("t5_idle", bus.arbiter_idle, 1'b1);

    // Reset in the middle of an I-cache transaction.
    fixed_lat = 8;
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 32'h0000_0300;
    tick();
    #1 check_output("t6_started", bus.pmem_read, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_output("t6_cmd_dropped", bus.pmem_read, 1'b0);
    check_output("t6_no_resp", bus.icache_pmem_resp, 1'b0);
    bus.dcache_pmem_read    = 1'b1;
    bus.dcache_pmem_address = 32'h0000_0400;
    tick();
    #1 check_output("t6_d_preferred", bus.pmem_address, 32'h0000_0400);
    wait_resp("t6_d", OWN_D, c);
    tick();
    bus.dcache_pmem_read = 1'b0;
    wait_resp("t6_i", OWN_I, c);
    tick();
    bus.icache_pmem_read = 1'b0;

    // Randomized traffic against the model.
    fixed_lat   = 0;
    spurious_en = 1'b1;
    i_resp_prev = 1'b0;
    d_resp_prev = 1'b0;
    p_resp_prev = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      apply_stimulus();
      #1;
      i_resp_prev = bus.icache_pmem_resp;
      d_resp_prev = bus.dcache_pmem_resp;
      p_resp_prev = bus.pref_pmem_resp;
    end
    rst = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
